// File: rtl/decompress_bit.sv
`default_nettype none
// ============================================================================
// Module   : decompress_bit
// Brief    : Block-floating-point IQ decompressor with packet framing check
//            and lockstep sideband delay (three register stages).
// Revision : 1.0
// ============================================================================
module decompress_bit #(
  parameter int NUM       = 7,
  parameter int RE_NUM    = 12,
  parameter int MAX_SHIFT = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sel,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_vld,
  input  logic [2*NUM-1:0]  i_din,
  input  logic [3:0]        i_shift,
  input  logic [6:0]        i_slot_idx,
  input  logic [3:0]        i_symb_idx,
  input  logic [8:0]        i_prb_idx,
  input  logic [3:0]        i_ch_type,
  input  logic [7:0]        i_info,
  output logic              o_sel,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_vld,
  output logic [31:0]       o_dout,
  output logic [6:0]        o_slot_idx,
  output logic [3:0]        o_symb_idx,
  output logic [8:0]        o_prb_idx,
  output logic [3:0]        o_type,
  output logic [7:0]        o_info,
  output logic              o_err,
  output logic [4:0]        o_re_cnt
);

  localparam logic [3:0] C_MAX_EXP = 4'(MAX_SHIFT);
  localparam logic [5:0] C_RE_LEN  = 6'(RE_NUM);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  typedef struct packed {
    logic       sel;
    logic       sop;
    logic       eop;
    logic       vld;
    logic [6:0] slot;
    logic [3:0] symb;
    logic [8:0] prb;
    logic [3:0] ch_type;
    logic [7:0] info;
    logic       err;
    logic [4:0] re_cnt;
  } side_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [3:0]     exp_lat_q, exp_lat_d;
  logic [4:0]     beat_idx;
  logic           beat_err;
  logic [3:0]     beat_exp;

  side_t          s1_side_q, s1_side_d, s2_side_q, s2_side_d, s3_side_q, s3_side_d;
  logic [NUM-1:0] s1_im_q, s1_im_d, s1_qm_q, s1_qm_d;
  logic [3:0]     s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
  logic [15:0]    s2_ia_q, s2_ia_d, s2_qa_q, s2_qa_d;
  logic [15:0]    s3_i_q, s3_i_d, s3_q_q, s3_q_d;

  // Framing FSM; cnt_q holds the index the next in-packet beat will carry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_lat_d = exp_lat_q;
    beat_idx  = 5'd0;
    beat_err  = 1'b0;
    beat_exp  = exp_lat_q;
    if (i_vld) begin
      if (i_sop) begin
        beat_exp  = (i_shift > C_MAX_EXP) ? C_MAX_EXP : i_shift;
        exp_lat_d = beat_exp;
        beat_err  = (i_shift > C_MAX_EXP) || (state_q == ST_PKT);
        if (i_eop) begin
          beat_err = beat_err || (C_RE_LEN != 6'd1);
          state_d  = ST_IDLE;
          cnt_d    = 5'd0;
        end else begin
          state_d  = ST_PKT;
          cnt_d    = 5'd1;
        end
      end else if (state_q == ST_PKT) begin
        beat_idx = cnt_q;
        cnt_d    = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
        if (i_eop) begin
          beat_err = (({1'b0, cnt_q} + 6'd1) != C_RE_LEN);
          state_d  = ST_IDLE;
          cnt_d    = 5'd0;
        end
      end else begin
        beat_err = 1'b1;
      end
    end
  end

  // Stage 1: capture; invalid beats carry zero data so they decode to zero.
  always_comb begin
    s1_side_d         = '0;
    s1_side_d.sel     = i_sel;
    s1_side_d.sop     = i_sop;
    s1_side_d.eop     = i_eop;
    s1_side_d.vld     = i_vld;
    s1_side_d.slot    = i_slot_idx;
    s1_side_d.symb    = i_symb_idx;
    s1_side_d.prb     = i_prb_idx;
    s1_side_d.ch_type = i_ch_type;
    s1_side_d.info    = i_info;
    s1_side_d.err     = beat_err;
    s1_side_d.re_cnt  = beat_idx;
    s1_im_d           = i_vld ? i_din[2*NUM-1:NUM] : '0;
    s1_qm_d           = i_vld ? i_din[NUM-1:0]     : '0;
    s1_exp_d          = i_vld ? beat_exp           : 4'd0;
  end

  // Stages 2 and 3: align mantissa to the MSB, then arithmetic shift right.
  always_comb begin
    s2_side_d = s1_side_q;
    s2_exp_d  = s1_exp_q;
    s2_ia_d   = {s1_im_q, {(16-NUM){1'b0}}};
    s2_qa_d   = {s1_qm_q, {(16-NUM){1'b0}}};
    s3_side_d = s2_side_q;
    s3_i_d    = 16'($signed(s2_ia_q) >>> s2_exp_q);
    s3_q_d    = 16'($signed(s2_qa_q) >>> s2_exp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      exp_lat_q <= 4'd0;
      s1_side_q <= '0;
      s1_im_q   <= '0;
      s1_qm_q   <= '0;
      s1_exp_q  <= 4'd0;
      s2_side_q <= '0;
      s2_exp_q  <= 4'd0;
      s2_ia_q   <= 16'd0;
      s2_qa_q   <= 16'd0;
      s3_side_q <= '0;
      s3_i_q    <= 16'd0;
      s3_q_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_lat_q <= exp_lat_d;
      s1_side_q <= s1_side_d;
      s1_im_q   <= s1_im_d;
      s1_qm_q   <= s1_qm_d;
      s1_exp_q  <= s1_exp_d;
      s2_side_q <= s2_side_d;
      s2_exp_q  <= s2_exp_d;
      s2_ia_q   <= s2_ia_d;
      s2_qa_q   <= s2_qa_d;
      s3_side_q <= s3_side_d;
      s3_i_q    <= s3_i_d;
      s3_q_q    <= s3_q_d;
    end
  end

  assign o_sel      = s3_side_q.sel;
  assign o_sop      = s3_side_q.sop;
  assign o_eop      = s3_side_q.eop;
  assign o_vld      = s3_side_q.vld;
  assign o_slot_idx = s3_side_q.slot;
  assign o_symb_idx = s3_side_q.symb;
  assign o_prb_idx  = s3_side_q.prb;
  assign o_type     = s3_side_q.ch_type;
  assign o_info     = s3_side_q.info;
  assign o_err      = s3_side_q.err;
  assign o_re_cnt   = s3_side_q.re_cnt;
  assign o_dout     = {s3_i_q, s3_q_q};

endmodule
`default_nettype wire

// File: tb/tb_decompress_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_decompress_bit
// Brief    : Table-driven directed bench for decompress_bit plus reset sequence.
// Revision : 1.0
// ============================================================================
module tb_decompress_bit;
  localparam int NUM = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_sel, i_sop, i_eop, i_vld;
  logic [2*NUM-1:0]  i_din;
  logic [3:0]        i_shift;
  logic [6:0]        i_slot_idx;
  logic [3:0]        i_symb_idx;
  logic [8:0]        i_prb_idx;
  logic [3:0]        i_ch_type;
  logic [7:0]        i_info;
  logic              o_sel, o_sop, o_eop, o_vld, o_err;
  logic [31:0]       o_dout;
  logic [6:0]        o_slot_idx;
  logic [3:0]        o_symb_idx;
  logic [8:0]        o_prb_idx;
  logic [3:0]        o_type;
  logic [7:0]        o_info;
  logic [4:0]        o_re_cnt;

  decompress_bit #(.NUM(NUM), .RE_NUM(12), .MAX_SHIFT(9)) dut (
    .clk(clk), .rst(rst),
    .i_sel(i_sel), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din(i_din), .i_shift(i_shift),
    .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx), .i_prb_idx(i_prb_idx),
    .i_ch_type(i_ch_type), .i_info(i_info),
    .o_sel(o_sel), .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld),
    .o_dout(o_dout),
    .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx),
    .o_type(o_type), .o_info(o_info), .o_err(o_err), .o_re_cnt(o_re_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld, sop, eop, sel;
    logic [3:0]  shift;
    logic [6:0]  im, qm;
    logic [6:0]  slot;
    logic [3:0]  symb;
    logic [8:0]  prb;
    logic [3:0]  typ;
    logic [7:0]  info;
    logic [15:0] ei, eq;
    logic        eerr;
    logic [4:0]  ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic sop, input logic eop, input logic [3:0] sh,
                     input logic [6:0] im, input logic [6:0] qm, input logic [15:0] ei,
                     input logic [15:0] eq, input logic err, input logic [4:0] cnt);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.shift = sh; v.im = im; v.qm = qm;
    v.sel = 1'($urandom); v.slot = 7'($urandom); v.symb = 4'($urandom);
    v.prb = 9'($urandom); v.typ = 4'($urandom); v.info = 8'($urandom);
    v.ei = ei; v.eq = eq; v.eerr = err; v.ecnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    i_vld = v.vld; i_sop = v.sop; i_eop = v.eop; i_sel = v.sel;
    i_shift = v.shift; i_din = {v.im, v.qm};
    i_slot_idx = v.slot; i_symb_idx = v.symb; i_prb_idx = v.prb;
    i_ch_type = v.typ; i_info = v.info;
  endtask

  task automatic drive_idle();
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_sel = 1'b0;
    i_shift = 4'd0; i_din = '0;
    i_slot_idx = 7'd0; i_symb_idx = 4'd0; i_prb_idx = 9'd0;
    i_ch_type = 4'd0; i_info = 8'd0;
  endtask

  task automatic check_out(input vec_t v, input string tag);
    check({tag, " dout"},  o_dout, {v.ei, v.eq});
    check({tag, " err"},   o_err, v.eerr);
    check({tag, " recnt"}, o_re_cnt, v.ecnt);
    check({tag, " frame"}, {o_sel, o_sop, o_eop, o_vld}, {v.sel, v.sop, v.eop, v.vld});
    check({tag, " side"},  {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info},
                           {v.slot, v.symb, v.prb, v.typ, v.info});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dout"},  o_dout, 64'd0);
    check({tag, " err"},   o_err, 64'd0);
    check({tag, " recnt"}, o_re_cnt, 64'd0);
    check({tag, " frame"}, {o_sel, o_sop, o_eop, o_vld}, 64'd0);
    check({tag, " side"},  {o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}, 64'd0);
  endtask

  initial begin
    vec_t v;
    // Reset must dominate even with busy, non-zero inputs.
    rst = 1'b1;
    add(1, 1, 0, 4'd2, 7'h20, 7'h40, 16'h0, 16'h0, 0, 5'd0);
    v = vecs.pop_back();
    drive(v);
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Packet A: 12 beats, exponent 2 from sop; i_shift changes mid-packet.
    add(1, 1, 0, 4'd2, 7'h20, 7'h40, 16'h1000, 16'hE000, 0, 5'd0);
    for (int k = 1; k < 12; k++)
      add(1, 0, k == 11, (k >= 4) ? 4'd5 : 4'd2, 7'(k), 7'h7F, 16'(k * 128), 16'hFF80, 0, 5'(k));
    // Packet B back-to-back: exponent 9.
    add(1, 1, 0, 4'd9, 7'h7F, 7'h3F, 16'hFFFF, 16'h003F, 0, 5'd0);
    for (int k = 1; k < 12; k++)
      add(1, 0, k == 11, 4'd0, 7'h40, 7'h01, 16'hFFC0, 16'h0001, 0, 5'(k));
    // Idle beat with garbage data must produce zeros.
    add(0, 0, 0, 4'd7, 7'h55, 7'h2A, 16'h0, 16'h0, 0, 5'd0);
    // Packet C: 10 beats, exponent 0, short packet flagged on eop.
    add(1, 1, 0, 4'd0, 7'h40, 7'h00, 16'h8000, 16'h0000, 0, 5'd0);
    for (int k = 1; k < 10; k++)
      add(1, 0, k == 9, 4'd3, 7'h01, 7'h02, 16'h0200, 16'h0400, k == 9, 5'(k));
    // Packet D: 14 beats, long packet flagged on eop.
    for (int k = 0; k < 14; k++)
      add(1, k == 0, k == 13, 4'd1, 7'h02, 7'h7E, 16'h0200, 16'hFE00, k == 13, 5'(k));
    // Packet E: truncated at beat 6 by a new sop, new packet completes cleanly.
    for (int k = 0; k < 6; k++)
      add(1, k == 0, 0, 4'd3, 7'h08, 7'h10, 16'h0200, 16'h0400, 0, 5'(k));
    for (int k = 0; k < 12; k++)
      add(1, k == 0, k == 11, 4'd0, 7'h08, 7'h10, 16'h1000, 16'h2000, k == 0, 5'(k));
    // Packet F: exponent 12 clamped to 9 and flagged on sop only.
    for (int k = 0; k < 12; k++)
      add(1, k == 0, k == 11, (k == 0) ? 4'hC : 4'd0, 7'h01, 7'h7F, 16'h0001, 16'hFFFF, k == 0, 5'(k));
    add(0, 0, 0, 4'd0, 7'h00, 7'h00, 16'h0, 16'h0, 0, 5'd0);
    // Stray valid in IDLE: flagged, decoded with latched exponent 9.
    add(1, 0, 0, 4'd0, 7'h40, 7'h01, 16'hFFC0, 16'h0001, 1, 5'd0);
    // Single-beat packet: length check fails.
    add(1, 1, 1, 4'd4, 7'h10, 7'h70, 16'h0200, 16'hFE00, 1, 5'd0);

    for (int p = 0; p < vecs.size() + 2; p++) begin
      if (p < vecs.size()) drive(vecs[p]);
      else drive_idle();
      @(posedge clk);
      #1;
      if (p >= 2) check_out(vecs[p - 2], $sformatf("vec%0d", p - 2));
    end

    // Reset mid-packet: in-flight beats discarded, exponent back to 0.
    vecs.delete();
    add(1, 1, 0, 4'd2, 7'h20, 7'h40, 16'h0, 16'h0, 0, 5'd0);
    add(1, 0, 0, 4'd2, 7'h01, 7'h01, 16'h0, 16'h0, 0, 5'd0);
    add(1, 0, 0, 4'd2, 7'h01, 7'h01, 16'h0, 16'h0, 0, 5'd0);
    add(1, 0, 0, 4'd0, 7'h20, 7'h40, 16'h4000, 16'h8000, 1, 5'd0);
    drive(vecs[0]);
    @(posedge clk);
    drive(vecs[1]);
    @(posedge clk);
    #1;
    drive(vecs[2]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_r0");
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    check_zero("rst_r1");
    drive(vecs[3]);
    @(posedge clk);
    #1;
    check_zero("rst_r2");
    drive_idle();
    @(posedge clk);
    #1;
    check_zero("rst_r3");
    @(posedge clk);
    #1;
    check_out(vecs[3], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
